// File: rtl/credit_rr_arbiter_if.sv
// Request/grant/credit bundle between the requesters and the credit round-robin arbiter.
interface credit_rr_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CREDIT_WIDTH = 5
);
  logic                    en;
  logic [NUM_REQ-1:0]      req;
  logic                    ret;
  logic [NUM_REQ-1:0]      gnt;
  logic                    gnt_valid;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    idle;
  logic                    err_overflow;

  modport master (
    output en, req, ret,
    input  gnt, gnt_valid, credits, idle, err_overflow
  );

  modport slave (
    input  en, req, ret,
    output gnt, gnt_valid, credits, idle, err_overflow
  );
endinterface

// File: rtl/credit_rr_arbiter.sv
// Round-robin arbiter sharing one downstream port among NUM_REQ requesters, with a credit
// counter bounding outstanding transactions.
module credit_rr_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CREDIT_WIDTH = 5,
  parameter int unsigned MAX_CREDITS  = 16
) (
  input logic                clk,
  input logic                rst,
  credit_rr_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CREDIT_WIDTH-1:0] MaxCred = CREDIT_WIDTH'(MAX_CREDITS);

  logic [PtrW-1:0]         r_ptr;
  logic [NUM_REQ-1:0]      r_gnt;
  logic                    r_gnt_valid;
  logic [CREDIT_WIDTH-1:0] r_credits;
  logic                    r_err;

  logic                    w_found;
  logic [PtrW-1:0]         w_sel;
  logic [PtrW-1:0]         w_ptr_nxt;
  logic                    w_issue;
  logic                    w_ret_acc;
  logic                    w_ovf;
  logic [CREDIT_WIDTH-1:0] w_credits_d;

  // Scan ptr, ptr+1, ... wrapping; first requester found wins.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req[PtrW'(idx)]) begin
        w_found = 1'b1;
        w_sel   = PtrW'(idx);
      end
    end
  end

  assign w_ptr_nxt = (w_sel == PtrW'(NUM_REQ - 1)) ? '0 : w_sel + PtrW'(1);

  // Credit check uses only the registered count, never a same-cycle return.
  assign w_issue   = bus.en && (r_credits != '0) && w_found;
  assign w_ret_acc = bus.ret && ((r_credits != MaxCred) || w_issue);
  assign w_ovf     = bus.ret && (r_credits == MaxCred) && !w_issue;

  always_comb begin
    w_credits_d = r_credits;
    if (w_issue && !w_ret_acc) begin
      w_credits_d = r_credits - CREDIT_WIDTH'(1);
    end else if (!w_issue && w_ret_acc) begin
      w_credits_d = r_credits + CREDIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_credits   <= MaxCred;
      r_err       <= 1'b0;
    end else begin
      r_credits   <= w_credits_d;
      r_gnt_valid <= w_issue;
      if (w_ovf) begin
        r_err <= 1'b1;
      end
      if (w_issue) begin
        r_gnt <= NUM_REQ'(1) << w_sel;
        r_ptr <= w_ptr_nxt;
      end else begin
        r_gnt <= '0;
      end
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.gnt_valid    = r_gnt_valid;
  assign bus.credits      = r_credits;
  assign bus.idle         = (r_credits == MaxCred);
  assign bus.err_overflow = r_err;

endmodule

// File: tb/tb_credit_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_credit_rr_arbiter;

  localparam int NReq = 4;
  localparam int CW   = 5;
  localparam int MaxC = 16;

  logic clk;
  logic rst;

  credit_rr_arbiter_if #(.NUM_REQ(NReq), .CREDIT_WIDTH(CW)) bus ();

  credit_rr_arbiter #(
    .NUM_REQ     (NReq),
    .CREDIT_WIDTH(CW),
    .MAX_CREDITS (MaxC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Model state: free credits, next requester to favour, sticky error, last grant index.
  int m_cred = MaxC;
  int m_ptr  = 0;
  bit m_err  = 1'b0;
  int m_gidx = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input bit r, input bit e, input bit [NReq-1:0] q, input bit rt);
    bit issue;
    logic [NReq-1:0] exp_gnt;
    @(negedge clk);
    rst     = r;
    bus.en  = e;
    bus.req = q;
    bus.ret = rt;
    if (!r) begin
      m_cred = MaxC;
      m_ptr  = 0;
      m_err  = 1'b0;
      m_gidx = -1;
    end else begin
      issue  = e && (m_cred > 0) && (q != 0);
      m_gidx = -1;
      if (issue) begin
        for (int k = 0; k < NReq; k++) begin
          if (m_gidx < 0 && q[(m_ptr + k) % NReq]) m_gidx = (m_ptr + k) % NReq;
        end
        m_ptr = (m_gidx + 1) % NReq;
      end
      if (issue && !rt) m_cred = m_cred - 1;
      else if (!issue && rt) begin
        if (m_cred == MaxC) m_err = 1'b1;
        else m_cred = m_cred + 1;
      end
    end
    @(posedge clk);
    #1;
    exp_gnt = '0;
    if (m_gidx >= 0) exp_gnt[m_gidx] = 1'b1;
    check("gnt", 32'(bus.gnt), 32'(exp_gnt));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(m_gidx >= 0));
    check("credits", 32'(bus.credits), 32'(m_cred));
    check("idle", 32'(bus.idle), 32'(m_cred == MaxC));
    check("err_overflow", 32'(bus.err_overflow), 32'(m_err));
  endtask

  initial begin
    rst     = 1'b0;
    bus.en  = 1'b1;
    bus.req = '0;
    bus.ret = 1'b0;

    // Reset dominates live requests and returns.
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_cred", 32'(bus.credits), 32'd16);
    check("rst_idle", 32'(bus.idle), 32'd1);
    check("rst_err", 32'(bus.err_overflow), 32'd0);

    // Round-robin rotation with all requesting.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 4'b1111, 1'b0);
      check("rr_seq", 32'(bus.gnt), 32'(4'b0001 << (i % 4)));
      check("rr_cred", 32'(bus.credits), 32'(15 - i));
    end

    // Credit exhaustion and single return.
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 4'b0001, 1'b0);
    check("exh_gnt", 32'(bus.gnt), 32'd0);
    check("exh_cred", 32'(bus.credits), 32'd0);
    step(1'b1, 1'b1, 4'b0001, 1'b1);
    check("exh_ret_gnt", 32'(bus.gnt), 32'd0);
    check("exh_ret_cred", 32'(bus.credits), 32'd1);
    step(1'b1, 1'b1, 4'b0001, 1'b0);
    check("exh_regnt", 32'(bus.gnt), 32'b0001);
    check("exh_regnt_cred", 32'(bus.credits), 32'd0);

    // Grant and return on the same edge at credits=5.
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 4'b0100, 1'b0);
    step(1'b1, 1'b1, 4'b0100, 1'b1);
    check("simul_gnt", 32'(bus.gnt), 32'b0100);
    check("simul_cred", 32'(bus.credits), 32'd5);

    // Overflow is sticky until reset.
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 1'b1);
    check("ovf_cred", 32'(bus.credits), 32'd16);
    check("ovf_err", 32'(bus.err_overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0011, 1'b0);
    check("ovf_sticky", 32'(bus.err_overflow), 32'd1);
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    check("ovf_clr", 32'(bus.err_overflow), 32'd0);

    // Full-credit return alongside a grant is accepted without error.
    step(1'b1, 1'b1, 4'b0010, 1'b1);
    check("full_ret_issue_err", 32'(bus.err_overflow), 32'd0);
    check("full_ret_issue_cred", 32'(bus.credits), 32'd16);

    // Pointer skip, then en=0 freezes grants and pointer but counts returns.
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 4'b0001, 1'b0);
    step(1'b1, 1'b1, 4'b1001, 1'b0);
    check("skip_hi", 32'(bus.gnt), 32'b1000);
    step(1'b1, 1'b1, 4'b1001, 1'b0);
    check("skip_wrap", 32'(bus.gnt), 32'b0001);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0001, 1'b0);
    check("en_pre_cred", 32'(bus.credits), 32'd10);
    step(1'b1, 1'b0, 4'b1111, 1'b1);
    check("en_off_gnt", 32'(bus.gnt), 32'd0);
    check("en_off_cred", 32'(bus.credits), 32'd11);
    step(1'b1, 1'b1, 4'b1111, 1'b0);
    check("en_ptr_kept", 32'(bus.gnt), 32'b0010);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 9) != 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/credit_rr_arbiter.md
# credit_rr_arbiter

Round-robin arbiter that shares one downstream resource port (e.g. a shared-memory or L1 request port) between NUM_REQ requesters, with an internal up/down credit counter bounding the number of outstanding transactions. Each grant consumes one credit; each completion pulse from the resource returns one. The block sits between per-warp request sources and the shared port, and issues at most one grant per cycle.

## Interface
- NUM_REQ, default 4: number of requesters (2..16).
- CREDIT_WIDTH, default 5: width of the credit counter.
- MAX_CREDITS, default 16: credits after reset; must satisfy 1 <= MAX_CREDITS <= 2^CREDIT_WIDTH - 1.

- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  grant enable; 0 blocks new grants, credit returns still counted.
- req  input  NUM_REQ  level per requester: bit i = 1 means requester i has a transaction pending.
- ret  input  1  credit return pulse; one credit per cycle high.
- gnt  output  NUM_REQ  registered one-hot grant, high for exactly one cycle per grant.
- gnt_valid  output  1  registered OR of gnt.
- credits  output  CREDIT_WIDTH  current available credit count.
- idle  output  1  credits == MAX_CREDITS (no outstanding transactions).
- err_overflow  output  1  sticky: ret received while credits == MAX_CREDITS.

## Operation
- State: credit count, round-robin pointer ptr (0..NUM_REQ-1), gnt register, err_overflow.
- Issue condition at an edge: rst=1, en=1, credits > 0, req != 0. Credit check uses the current registered count only; a same-cycle ret does not enable a grant at credits == 0.
- Selection: first i with req[i]=1 scanning ptr, ptr+1, ... wrapping modulo NUM_REQ. On issue: gnt <= one-hot(i), ptr <= (i+1) mod NUM_REQ. No issue: gnt <= 0, ptr unchanged.
- Credit update per edge: credits <= credits - issue + ret_accepted.
  - Issue and ret same edge: count unchanged.
  - ret with credits == MAX_CREDITS and no issue: ret ignored (count stays MAX_CREDITS), err_overflow <= 1. Counter never wraps.
  - ret with credits == MAX_CREDITS and issue same edge: ret accepted, count unchanged, no error.
  - Underflow impossible: issue gated by credits > 0.
- err_overflow clears only on reset.
- Requester protocol: on seeing gnt[i]=1 a requester updates req[i] in that same cycle (drop if no further transaction). Keeping req[i] high means another pending transaction; it is eligible again once the pointer returns to it.
- en=0: no grants, ptr frozen, returns still accepted.

## Timing
- Reset (rst=0 at an edge): credits=MAX_CREDITS, gnt=0, gnt_valid=0, ptr=0, idle=1, err_overflow=0. Reset wins over all other inputs; outstanding transactions are forgotten, so later returns for them may set err_overflow.
- Latency: req sampled at edge k -> gnt visible in cycle after edge k (1 cycle). Back-to-back grants every cycle while credits last.
- credits, idle reflect the registered count; a grant at edge k and its credit decrement appear together after edge k.
- Fairness: with all NUM_REQ requesters continuously requesting and credits available, each receives exactly one grant per NUM_REQ consecutive grants.

## Test plan
- Reset: hold rst=0 two cycles with req=4'b1111, ret=1 -> gnt=0, credits=16, idle=1, err_overflow=0.
- Round-robin: req=4'b1111 held, ret=0, MAX_CREDITS=16 -> gnt sequence 0001,0010,0100,1000,0001,... one per cycle; credits 15,14,13,12,...
- Credit exhaustion: req=4'b0001 held, no returns -> 16 grants then gnt=0, credits=0; single ret pulse -> credits=1 next cycle, one more grant the cycle after, credits=0.
- Simultaneous grant and return: credits=5, req=4'b0100, ret=1 same cycle -> gnt=0100, credits stays 5.
- Overflow: after reset, ret=1 one cycle with req=0 -> credits stays 16, err_overflow=1 and remains 1 until rst=0.
- Pointer skip and en: ptr=1, req=4'b1001 -> gnt=1000, then 0001; en=0 with req=4'b1111 and ret=1 at credits=10 -> no grants, credits=11, ptr unchanged.
